// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device transmitter for a PS/2 port. It sends one command byte per
// request: it inhibits the bus, drives the start bit, and then shifts out the
// data, parity and stop bits on the falling edges of the device clock. It then
// samples the device acknowledge.
//
// Parameters
//   SYS_FREQ    system clock frequency in Hz
//   INHIBIT_US  time the clock line is held low before the start bit
//   TIMEOUT_US  watchdog for the device-clocked part of the transfer
//   FILTER_LEN  consecutive equal samples needed to accept a line change
//
// Ports
//   clk          system clock, all logic on its rising edge
//   reset        synchronous active-low reset
//   tx_start     one-cycle request to send tx_data (honoured only when idle)
//   tx_data      command byte, captured when tx_start is accepted
//   ps2_clk_i    PS/2 clock pad input (asynchronous)
//   ps2_data_i   PS/2 data pad input (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   tx_busy      high from acceptance until completion
//   tx_done      one-cycle pulse: device acknowledged
//   tx_err       one-cycle pulse: device NACK or watchdog timeout
module ps2_host_tx #(
    parameter int SYS_FREQ   = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15_000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INHIBIT_CYC = SYS_FREQ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = SYS_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int FLT_W       = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    // Line conditioning
    logic [1:0]       r_clkSync;
    logic [1:0]       r_dataSync;
    logic [FLT_W-1:0] r_clkCnt;
    logic [FLT_W-1:0] r_dataCnt;
    logic             r_clkFilt;
    logic             r_dataFilt;
    logic             r_clkFiltD;
    logic             w_fallTick;

    // Transfer state
    state_t           r_state;
    state_t           w_state;
    logic [INH_W-1:0] r_inhCnt;
    logic [INH_W-1:0] w_inhCnt;
    logic [WD_W-1:0]  r_wdCnt;
    logic [WD_W-1:0]  w_wdCnt;
    logic [3:0]       r_bitCnt;
    logic [3:0]       w_bitCnt;
    logic [9:0]       r_frame;
    logic [9:0]       w_frame;
    logic             r_ack;
    logic             w_ack;
    logic             r_clkOe;
    logic             w_clkOe;
    logic             r_dataOe;
    logic             w_dataOe;
    logic             r_busy;
    logic             w_busy;
    logic             r_done;
    logic             w_done;
    logic             r_err;
    logic             w_err;
    logic             w_timeout;

    // Two-flop synchronizers followed by a run-length filter. A filtered line
    // only moves once FILTER_LEN consecutive synchronized samples disagree with
    // it, so short glitches never reach the state machine.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkCnt   <= '0;
            r_dataCnt  <= '0;
            r_clkFilt  <= 1'b1;
            r_dataFilt <= 1'b1;
            r_clkFiltD <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk_i};
            r_dataSync <= {r_dataSync[0], ps2_data_i};
            r_clkFiltD <= r_clkFilt;

            if (r_clkSync[1] == r_clkFilt) begin
                r_clkCnt <= '0;
            end else if (r_clkCnt == FLT_W'(FILTER_LEN - 1)) begin
                r_clkFilt <= r_clkSync[1];
                r_clkCnt  <= '0;
            end else begin
                r_clkCnt <= r_clkCnt + FLT_W'(1);
            end

            if (r_dataSync[1] == r_dataFilt) begin
                r_dataCnt <= '0;
            end else if (r_dataCnt == FLT_W'(FILTER_LEN - 1)) begin
                r_dataFilt <= r_dataSync[1];
                r_dataCnt  <= '0;
            end else begin
                r_dataCnt <= r_dataCnt + FLT_W'(1);
            end
        end
    end

    assign w_fallTick = r_clkFiltD & ~r_clkFilt;
    assign w_timeout  = (r_wdCnt == WD_W'(TIMEOUT_CYC - 1));

    // State and output registers. Every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_inhCnt <= '0;
            r_wdCnt  <= '0;
            r_bitCnt <= '0;
            r_frame  <= '0;
            r_ack    <= 1'b0;
            r_clkOe  <= 1'b0;
            r_dataOe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_inhCnt <= w_inhCnt;
            r_wdCnt  <= w_wdCnt;
            r_bitCnt <= w_bitCnt;
            r_frame  <= w_frame;
            r_ack    <= w_ack;
            r_clkOe  <= w_clkOe;
            r_dataOe <= w_dataOe;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    // Next-state logic. The frame is kept as a shift register, so the bit to
    // present on each falling edge is always r_frame[0]. The watchdog check
    // at the bottom takes priority over whatever the device-clocked states
    // decided in the same cycle.
    always_comb begin
        w_state  = r_state;
        w_inhCnt = r_inhCnt;
        w_wdCnt  = r_wdCnt;
        w_bitCnt = r_bitCnt;
        w_frame  = r_frame;
        w_ack    = r_ack;
        w_clkOe  = r_clkOe;
        w_dataOe = r_dataOe;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_err    = 1'b0;

        case (r_state)
            IDLE: begin
                w_clkOe  = 1'b0;
                w_dataOe = 1'b0;
                w_busy   = 1'b0;
                if (tx_start) begin
                    // Odd parity: parity bit set when the data has an even count of ones
                    w_frame  = {1'b1, ~^tx_data, tx_data};
                    w_inhCnt = '0;
                    w_clkOe  = 1'b1;
                    w_busy   = 1'b1;
                    w_state  = INHIBIT;
                end
            end

            INHIBIT: begin
                if (r_inhCnt == INH_W'(INHIBIT_CYC - 1)) begin
                    w_clkOe  = 1'b0;
                    w_dataOe = 1'b1;
                    w_bitCnt = '0;
                    w_wdCnt  = '0;
                    w_state  = SHIFT;
                end else begin
                    w_inhCnt = r_inhCnt + INH_W'(1);
                end
            end

            SHIFT: begin
                w_wdCnt = r_wdCnt + WD_W'(1);
                if (w_fallTick) begin
                    w_dataOe = ~r_frame[0];
                    w_frame  = {1'b0, r_frame[9:1]};
                    w_bitCnt = r_bitCnt + 4'd1;
                    // The tenth bit is the stop bit, which releases the data line
                    if (r_bitCnt == 4'd9) begin
                        w_state = WAIT_ACK;
                    end
                end
            end

            WAIT_ACK: begin
                w_wdCnt = r_wdCnt + WD_W'(1);
                if (w_fallTick) begin
                    w_ack   = ~r_dataFilt;
                    w_state = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                w_wdCnt = r_wdCnt + WD_W'(1);
                if (r_clkFilt && r_dataFilt) begin
                    w_done  = r_ack;
                    w_err   = ~r_ack;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end
            end

            default: begin
                w_clkOe  = 1'b0;
                w_dataOe = 1'b0;
                w_busy   = 1'b0;
                w_state  = IDLE;
            end
        endcase

        // Watchdog overrides a device that stops clocking partway through
        if ((r_state == SHIFT || r_state == WAIT_ACK || r_state == WAIT_IDLE) && w_timeout) begin
            w_clkOe  = 1'b0;
            w_dataOe = 1'b0;
            w_busy   = 1'b0;
            w_done   = 1'b0;
            w_err    = 1'b1;
            w_state  = IDLE;
        end
    end

    assign ps2_clk_oe  = r_clkOe;
    assign ps2_data_oe = r_dataOe;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_err      = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Drives ps2_host_tx with a behavioural PS/2 device on wired-AND bus lines.
// The device records each bit on its rising clock edge. The recorded frames
// are compared with a frame built from the byte value (data, odd parity, stop).
module tb_ps2_host_tx;

    localparam int SYS_FREQ    = 10_000_000;
    localparam int INHIBIT_US  = 20;
    localparam int TIMEOUT_US  = 500;
    localparam int FILTER_LEN  = 8;
    localparam int INHIBIT_CYC = SYS_FREQ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = SYS_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int HALF        = 40;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       devClk   = 1'b1;
    logic       devData  = 1'b1;
    logic       ps2ClkLine;
    logic       ps2DataLine;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int errCount   = 0;
    int bothCount  = 0;

    // Open-drain bus: either side may pull a line low
    assign ps2ClkLine  = devClk & ~ps2_clk_oe;
    assign ps2DataLine = devData & ~ps2_data_oe;

    ps2_host_tx #(
        .SYS_FREQ   (SYS_FREQ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_i   (ps2ClkLine),
        .ps2_data_i  (ps2DataLine),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    // Tally of completion pulses seen on the outputs
    always @(posedge clk) begin
        if (tx_done) doneCount <= doneCount + 1;
        if (tx_err) errCount <= errCount + 1;
        if (tx_done && tx_err) bothCount <= bothCount + 1;
    end

    // Hard stop in case the sequence below wedges
    initial begin
        #(10 * 200_000);
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic logic [9:0] refFrame(input logic [7:0] data);
        logic parity;
        parity = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, parity, data};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        tx_data  = data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Counts the cycles for which the host holds the clock line low
    task automatic measureInhibit(output int cycles);
        int guard;
        guard = 0;
        while (!ps2_clk_oe && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cycles = 0;
        while (ps2_clk_oe && cycles < INHIBIT_CYC + 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Device side: ten clock pulses reading D0..D7, parity and stop, then an
    // eleventh with an optional acknowledge. glitchBit inserts a short low
    // pulse on the clock before that bit. startBit fires a stray tx_start.
    task automatic runDevice(input logic [7:0] data, input logic ack, input int glitchBit,
                             input int startBit, input int stopAfter, output logic [9:0] seen);
        seen = '0;
        tick(30);
        for (int k = 0; k < 10; k++) begin
            if (k == stopAfter) return;
            if (k == glitchBit) begin
                devClk = 1'b0;
                tick(3);
                devClk = 1'b1;
                tick(30);
            end
            if (k == startBit) begin
                tx_data  = ~data;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
            end
            devClk = 1'b0;
            tick(HALF);
            devClk = 1'b1;
            seen[k] = ps2DataLine;
            tick(HALF);
        end
        if (ack) devData = 1'b0;
        tick(HALF / 2);
        devClk = 1'b0;
        tick(HALF);
        devClk = 1'b1;
        tick(HALF / 2);
        devData = 1'b1;
    endtask

    task automatic doTransfer(input logic [7:0] data, input logic ack, input int glitchBit,
                              input int startBit, input string name);
        int         d0;
        int         e0;
        int         cycles;
        int         guard;
        logic [9:0] seen;
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(data);
        checkOutput({name, "_busy_start"}, tx_busy, 1);
        measureInhibit(cycles);
        checkOutput({name, "_inhibit_len"}, cycles, INHIBIT_CYC);
        checkOutput({name, "_start_bit"}, ps2_data_oe, 1);
        runDevice(data, ack, glitchBit, startBit, 99, seen);
        guard = 0;
        while (tx_busy && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_busy_release"}, tx_busy, 0);
        tick(5);
        checkOutput({name, "_frame"}, seen, refFrame(data));
        checkOutput({name, "_done_pulses"}, doneCount - d0, ack ? 1 : 0);
        checkOutput({name, "_err_pulses"}, errCount - e0, ack ? 0 : 1);
        checkOutput({name, "_lines_released"}, {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
    endtask

    initial begin
        int         cycles;
        int         d0;
        int         e0;
        logic [9:0] seen;
        logic [7:0] rndData;
        logic       rndAck;

        $display("[TB] reset check");
        reset = 1'b0;
        tick(5);
        checkOutput("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err}, 0);
        reset = 1'b1;
        tick(20);

        $display("[TB] directed ACK and NACK transfers");
        doTransfer(8'hF4, 1'b1, -1, -1, "f4_ack");
        doTransfer(8'hFF, 1'b0, -1, -1, "ff_nack");

        $display("[TB] clock glitch and stray start");
        doTransfer(8'h5A, 1'b1, 3, -1, "glitch");
        doTransfer(8'h3C, 1'b1, -1, 4, "stray_start");
        tick(20);
        checkOutput("stray_start_no_retx", {ps2_clk_oe, tx_busy}, 0);

        $display("[TB] watchdog timeout");
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(8'h00);
        measureInhibit(cycles);
        checkOutput("to_start_bit", ps2_data_oe, 1);
        cycles = 0;
        while (!tx_err && cycles < TIMEOUT_CYC + 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("to_latency", cycles, TIMEOUT_CYC);
        checkOutput("to_lines", {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
        tick(5);
        checkOutput("to_pulses", {doneCount - d0, errCount - e0}, {32'd0, 32'd1});

        $display("[TB] reset during shift");
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(8'hA5);
        measureInhibit(cycles);
        runDevice(8'hA5, 1'b1, -1, -1, 3, seen);
        reset    = 1'b0;
        tx_start = 1'b1;
        tick(1);
        checkOutput("rst_mid_lines", {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
        tx_start = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(30);
        checkOutput("rst_mid_idle", {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
        checkOutput("rst_mid_pulses", (doneCount - d0) + (errCount - e0), 0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 6; i++) begin
            rndData = 8'($urandom);
            rndAck  = 1'($urandom_range(0, 1));
            doTransfer(rndData, rndAck, -1, -1, $sformatf("rnd%0d", i));
        end

        checkOutput("never_both_pulses", bothCount, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
